// File: rtl/bit_packer_pkg.sv
// Shared definitions for the bit packer: default widths, the FSM state type
// and a helper that sizes the accumulator fill counter.
package bit_packer_pkg;

  localparam int DEF_DATA_IN_WIDTH = 32;
  localparam int DEF_LEN_IN_WIDTH  = 6;
  localparam int DEF_OUT_WIDTH     = 32;

  typedef enum logic {
    PACK  = 1'b0,
    DRAIN = 1'b1
  } pack_state_e;

  // The fill count must reach 2*OUT_WIDTH-1 (a word held plus a code just appended).
  function automatic int fill_width(input int out_width);
    return $clog2(2 * out_width + 1);
  endfunction

endpackage

// File: rtl/bit_packer_code_aligner.sv
// Combinational barrel shifter: places an in_len-bit code, MSB first, at a
// bit offset measured from the top of a 2*OUT_WIDTH field.
module code_aligner
  import bit_packer_pkg::*;
#(
  parameter  int DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
  parameter  int LEN_IN_WIDTH  = DEF_LEN_IN_WIDTH,
  parameter  int OUT_WIDTH     = DEF_OUT_WIDTH,
  localparam int AW            = 2 * OUT_WIDTH,
  localparam int FW            = fill_width(OUT_WIDTH)
) (
  input  logic [DATA_IN_WIDTH-1:0] code_i,
  input  logic [LEN_IN_WIDTH-1:0]  len_i,
  input  logic [FW-1:0]            offset_i,
  output logic [AW-1:0]            field_o
);

  logic [DATA_IN_WIDTH-1:0] mask;
  logic [DATA_IN_WIDTH-1:0] code_m;
  logic [AW-1:0]            wide;
  logic [FW-1:0]            lsh;

  always_comb begin
    mask = '1;
    if (len_i < LEN_IN_WIDTH'(DATA_IN_WIDTH)) begin
      mask = ~({DATA_IN_WIDTH{1'b1}} << len_i);
    end
    code_m = code_i & mask;
    wide   = {{(AW - DATA_IN_WIDTH){1'b0}}, code_m};
    // Left-justify the code in the field, then slide it down past the held bits.
    lsh     = FW'(AW) - FW'(len_i);
    field_o = (wide << lsh) >> offset_i;
  end

endmodule

// File: rtl/bit_packer.sv
// Variable-length code packer: appends codes MSB-first into fixed-width words
// and drains a final partial word when a stream is flushed.
//
// state | meaning
// PACK  | accepting codes; full words are emitted as they complete
// DRAIN | flush seen; emitting held words, the last one tagged out_last
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int DATA_IN_WIDTH = DEF_DATA_IN_WIDTH,
  parameter int LEN_IN_WIDTH  = DEF_LEN_IN_WIDTH,
  parameter int OUT_WIDTH     = DEF_OUT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_IN_WIDTH-1:0] in_data,
  input  logic [LEN_IN_WIDTH-1:0]  in_len,
  input  logic                     in_flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic [LEN_IN_WIDTH:0]    out_bits,
  output logic                     out_last
);

  localparam int AW = 2 * OUT_WIDTH;
  localparam int FW = fill_width(OUT_WIDTH);
  localparam int OB = LEN_IN_WIDTH + 1;

  if (DATA_IN_WIDTH > OUT_WIDTH) begin : g_bad_cfg
    $error("bit_packer: DATA_IN_WIDTH must not exceed OUT_WIDTH");
  end

  pack_state_e             state_q, state_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [FW-1:0]           fill_q, fill_d;

  logic                    full, last_word;
  logic                    in_fire, out_fire;
  logic [LEN_IN_WIDTH-1:0] len_c;
  logic [AW-1:0]           base_acc, placed;
  logic [FW-1:0]           base_fill;

  always_comb begin
    in_ready  = (state_q == PACK) && (fill_q < FW'(OUT_WIDTH));
    full      = fill_q >= FW'(OUT_WIDTH);
    out_valid = (state_q == DRAIN) || full;
    last_word = (state_q == DRAIN) && (fill_q <= FW'(OUT_WIDTH));
    out_last  = last_word;
    out_data  = '0;
    out_bits  = '0;
    if (out_valid) begin
      out_data = acc_q[AW-1 -: OUT_WIDTH];
      out_bits = full ? OB'(OUT_WIDTH) : OB'(fill_q);
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    len_c    = (in_len > LEN_IN_WIDTH'(DATA_IN_WIDTH)) ? LEN_IN_WIDTH'(DATA_IN_WIDTH) : in_len;
    // The output word leaves first so a same-cycle code lands behind the remainder.
    base_acc  = acc_q;
    base_fill = fill_q;
    if (out_fire) begin
      if (last_word) begin
        base_acc  = '0;
        base_fill = '0;
      end else begin
        base_acc  = acc_q << OUT_WIDTH;
        base_fill = fill_q - FW'(OUT_WIDTH);
      end
    end
  end

  code_aligner #(
    .DATA_IN_WIDTH(DATA_IN_WIDTH),
    .LEN_IN_WIDTH (LEN_IN_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_aligner (
    .code_i  (in_data),
    .len_i   (len_c),
    .offset_i(base_fill),
    .field_o (placed)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = base_acc;
    fill_d  = base_fill;
    if (in_fire) begin
      acc_d  = base_acc | placed;
      fill_d = base_fill + FW'(len_c);
    end
    case (state_q)
      PACK:    if (in_fire && in_flush) state_d = DRAIN;
      DRAIN:   if (out_fire && last_word) state_d = PACK;
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PACK;
      acc_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: a bit-queue reference model checked every
// cycle, directed literal scenarios, then randomized traffic with resets.
module tb_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [5:0]  in_len = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [6:0]  out_bits;
  logic        out_last;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  bit          pend[$];
  bit          draining = 1'b0;
  logic [39:0] got[$];

  always #5 clk = ~clk;

  bit_packer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_flush (in_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_bits (out_bits),
    .out_last (out_last)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected outputs derived purely from the pending bit stream.
  function automatic void model_out(output logic ir, output logic ov, output logic [31:0] d,
                                    output logic [6:0] b, output logic l);
    int n;
    ir = !draining && (pend.size() < 32);
    ov = draining || (pend.size() >= 32);
    n  = (pend.size() >= 32) ? 32 : pend.size();
    d  = '0;
    b  = '0;
    l  = 1'b0;
    if (ov) begin
      for (int i = 0; i < n; i++) d[31-i] = pend[i];
      b = 7'(n);
      l = draining && (pend.size() <= 32);
    end
  endfunction

  always @(posedge clk) begin
    logic ir, ov, l;
    logic [31:0] d;
    logic [6:0] b;
    int len;
    if (rst) begin
      pend.delete();
      draining = 1'b0;
      started  = 1'b1;
    end else begin
      model_out(ir, ov, d, b, l);
      if (ov && out_ready) begin
        if (l) begin
          pend.delete();
          draining = 1'b0;
        end else begin
          for (int i = 0; i < 32; i++) void'(pend.pop_front());
        end
      end
      if (in_valid && ir) begin
        len = (in_len > 6'd32) ? 32 : int'(in_len);
        for (int i = len - 1; i >= 0; i--) pend.push_back(in_data[i]);
        if (in_flush) draining = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic ir, ov, l;
    logic [31:0] d;
    logic [6:0] b;
    if (started) begin
      model_out(ir, ov, d, b, l);
      check("in_ready", in_ready, ir);
      check("out_valid", out_valid, ov);
      if (ov) begin
        check("out_data", out_data, d);
        check("out_bits", out_bits, b);
        check("out_last", out_last, l);
      end
      if (out_valid && out_ready && !rst) got.push_back({out_last, out_bits, out_data});
    end
  end

  task automatic send(input logic [31:0] d, input logic [5:0] l, input logic f);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    in_flush = f;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (got.size() < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (got.size() < n) check("wait_words_timeout", 64'(got.size()), 64'(n));
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] d,
                          input logic [6:0] b, input logic l);
    check({name, "_present"}, 64'(got.size() > idx), 64'(1));
    if (got.size() > idx) check(name, got[idx], {l, b, d});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_out_last", out_last, 0);

    got.delete();
    send(32'h11, 6'd8, 1'b0);
    send(32'h22, 6'd8, 1'b0);
    send(32'h33, 6'd8, 1'b0);
    send(32'h44, 6'd8, 1'b0);
    wait_words(1);
    chk_word("pack_word", 0, 32'h11223344, 7'd32, 1'b0);

    got.delete();
    repeat (3) send(32'hAA, 6'd8, 1'b0);
    send(32'hBEEF, 6'd16, 1'b1);
    wait_words(2);
    chk_word("straddle_w0", 0, 32'hAAAAAABE, 7'd32, 1'b0);
    chk_word("straddle_w1", 1, 32'hEF000000, 7'd8, 1'b1);

    got.delete();
    send(32'b101, 6'd3, 1'b1);
    wait_words(1);
    chk_word("short_flush", 0, 32'hA0000000, 7'd3, 1'b1);
    check("short_flush_ready", in_ready, 1);

    got.delete();
    send(32'h0, 6'd0, 1'b1);
    wait_words(1);
    chk_word("empty_flush", 0, 32'h0, 7'd0, 1'b1);

    got.delete();
    send(32'hFFFFFFFF, 6'd63, 1'b1);
    wait_words(1);
    chk_word("clamp_full_last", 0, 32'hFFFFFFFF, 7'd32, 1'b1);

    got.delete();
    out_ready = 1'b0;
    repeat (3) send(32'hAA, 6'd8, 1'b0);
    send(32'hBBBB, 6'd16, 1'b0);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_data", out_data, 32'hAAAAAABB);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_frozen_data", out_data, 32'hAAAAAABB);
    check("bp_frozen_bits", out_bits, 32);
    check("bp_no_words", got.size(), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_word("bp_word", 0, 32'hAAAAAABB, 7'd32, 1'b0);
    check("bp_after_valid", out_valid, 0);
    send(32'h0, 6'd0, 1'b1);
    wait_words(2);
    chk_word("bp_residual", 1, 32'hBB000000, 7'd8, 1'b1);

    got.delete();
    out_ready = 1'b0;
    send(32'h1234, 6'd16, 1'b0);
    send(32'h56, 6'd8, 1'b1);
    check("drain_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_drain_valid", out_valid, 0);
    check("rst_drain_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_drain_no_words", got.size(), 0);
    send(32'hDE, 6'd8, 1'b0);
    send(32'hAD, 6'd8, 1'b0);
    send(32'hBE, 6'd8, 1'b0);
    send(32'hEF, 6'd8, 1'b1);
    wait_words(1);
    chk_word("fresh_stream", 0, 32'hDEADBEEF, 7'd32, 1'b1);

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_len    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
      in_flush  = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 32, meaning maximum code length in bits per input beat.
REQ-002 SHALL have parameter LEN_IN_WIDTH, default 6, meaning width of the length field; it SHALL hold the value DATA_IN_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 32, meaning packed output word width; DATA_IN_WIDTH <= OUT_WIDTH is required.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, input beat present.
REQ-007 SHALL have port in_ready, output, 1, input beat accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data, input, DATA_IN_WIDTH, code right-aligned; only the low in_len bits are used.
REQ-009 SHALL have port in_len, input, LEN_IN_WIDTH, code length 0..DATA_IN_WIDTH.
REQ-010 SHALL have port in_flush, input, 1, qualified by in_valid; marks the final beat of a stream.
REQ-011 SHALL have port out_valid, output, 1, output word present.
REQ-012 SHALL have port out_ready, input, 1, output word consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port out_data, output, OUT_WIDTH, packed bits MSB-first, zero-padded at the LSB end.
REQ-014 SHALL have port out_bits, output, LEN_IN_WIDTH+1, count of meaningful bits in out_data (0..OUT_WIDTH).
REQ-015 SHALL have port out_last, output, 1, final word of a flushed stream.

Function
REQ-016 SHALL keep an accumulator of 2*OUT_WIDTH bits and a fill count; each accepted code is appended immediately below the bits already held (first-accepted bit is the out_data MSB).
REQ-017 SHALL clamp in_len values greater than DATA_IN_WIDTH to DATA_IN_WIDTH; in_len = 0 beats are accepted and change no data.
REQ-018 SHALL drive in_ready = 1 only in state PACK with fill < OUT_WIDTH; in_ready SHALL depend on registered state only (no combinational path from out_ready or in_valid).
REQ-019 SHALL assert out_valid whenever fill >= OUT_WIDTH, presenting the top OUT_WIDTH accumulator bits with out_bits = OUT_WIDTH.
REQ-020 SHALL, on an output handshake, shift the accumulator left by OUT_WIDTH and reduce fill by OUT_WIDTH in the same cycle.
REQ-021 SHALL, when input and output handshakes occur in the same cycle, yield fill_next = fill + len - OUT_WIDTH with the new code appended after the shift.
REQ-022 SHALL provide latency of one cycle: a word completed by an accepted beat is on out_data with out_valid the following cycle.
REQ-023 SHALL hold out_data, out_bits and out_last stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL implement states PACK and DRAIN; PACK -> DRAIN on an accepted beat with in_flush = 1; DRAIN -> PACK on the handshake of the word carrying out_last.
REQ-025 SHALL, in DRAIN, emit remaining full words, then one final word holding the residual fill bits with out_bits = residual count and out_last = 1.
REQ-026 SHALL, if residual is 0 after at least one full word of the stream, set out_last on the final full word and emit no extra word.
REQ-027 SHALL, if the stream contained zero bits in total at flush, emit one word out_data = 0, out_bits = 0, out_last = 1.
REQ-028 SHALL hold in_ready = 0 throughout DRAIN.

Reset
REQ-029 SHALL, when rst is high at a clock edge, set state PACK, fill 0 and accumulator 0, and drive in_ready = 1, out_valid = 0, out_data = 0, out_bits = 0 and out_last = 0 from the next cycle.
REQ-030 SHALL discard any partial stream, including DRAIN in progress, on reset with no words emitted for it.

Structure
REQ-031 SHALL place the state enum (PACK, DRAIN) and the default width constants in shared package bit_packer_pkg.
REQ-032 SHALL use one sub-module, code_aligner: a combinational barrel shifter placing an in_len-bit code at a fill offset inside a 2*OUT_WIDTH field.

Verification (defaults, out_ready = 1 unless stated)
REQ-033 SHALL cover packing: four beats of len 8 with data 0x11, 0x22, 0x33, 0x44 -> one word 0x11223344, out_bits 32, out_last 0.
REQ-034 SHALL cover straddle and flush: three beats of len 8 with data 0xAA, then len 16 data 0xBEEF with flush -> 0xAAAAAABE (bits 32, last 0), then 0xEF000000 (bits 8, last 1).
REQ-035 SHALL cover a short flush: len 3 data 0b101 with flush -> 0xA0000000, out_bits 3, out_last 1, then in_ready returns to 1.
REQ-036 SHALL cover backpressure: out_ready = 0 with fill reaching 40 -> in_ready 0, out_data frozen; out_ready = 1 -> word accepted and fill becomes 8.
REQ-037 SHALL cover empty flush: len 0 with flush on a fresh stream -> single word 0x00000000, out_bits 0, out_last 1.
REQ-038 SHALL cover reset mid-DRAIN: assert rst -> next cycle out_valid 0, in_ready 1, and a fresh 32-bit stream packs correctly.
